// File: rtl/fsm_control_param_pkg.sv
// Shared definitions for the flow-control FSM: one-hot state codes and
// the default FIFO ordering used by the threshold and flag vectors.
package fsm_control_param_pkg;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] ST_RESET  = 5'b00001;
  localparam logic [STATE_W-1:0] ST_INIT   = 5'b00010;
  localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00100;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 5'b01000;
  localparam logic [STATE_W-1:0] ST_ERROR  = 5'b10000;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = ST_RESET,
    S_INIT   = ST_INIT,
    S_IDLE   = ST_IDLE,
    S_ACTIVE = ST_ACTIVE,
    S_ERROR  = ST_ERROR
  } state_t;

  // Default FIFO positions within every per-FIFO vector
  localparam int FIFO_MF  = 0;
  localparam int FIFO_VC0 = 1;
  localparam int FIFO_VC1 = 2;
  localparam int FIFO_D0  = 3;
  localparam int FIFO_D1  = 4;

  localparam int DEF_NUM_FIFOS = 5;
  localparam int DEF_TH_W      = 4;

endpackage

// File: rtl/fsm_cfg_reg.sv
// Threshold holding register: loads while enabled, clears synchronously
// when clr_n is low, otherwise keeps its value.
module fsm_cfg_reg
  import fsm_control_param_pkg::*;
#(
  parameter int W = DEF_NUM_FIFOS * DEF_TH_W
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fsm_control_param.sv
// Control FSM for the flow-controlled FIFO datapath: captures thresholds
// during INIT, tracks IDLE/ACTIVE from empty flags, and latches a sticky ERROR.
module fsm_control_param
  import fsm_control_param_pkg::*;
#(
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int TH_W      = DEF_TH_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [NUM_FIFOS*TH_W-1:0] umbral_in,
  input  logic [NUM_FIFOS-1:0]      err_mask,
  input  logic [NUM_FIFOS-1:0]      fifo_error,
  input  logic [NUM_FIFOS-1:0]      fifo_empty,
  output logic [NUM_FIFOS*TH_W-1:0] umbrales_out,
  output logic [STATE_W-1:0]        state_out,
  output logic                      idle_out,
  output logic                      active_out,
  output logic                      error_out,
  output logic [NUM_FIFOS-1:0]      error_src
);

  state_t                 state_reg;
  state_t                 state_next;
  logic [NUM_FIFOS-1:0]   err_masked;
  logic                   err_hit;
  logic                   all_empty;
  logic                   cfg_clr_n;
  logic                   cfg_load;

  assign err_masked = fifo_error & ~err_mask;
  assign err_hit    = |err_masked;
  assign all_empty  = &fifo_empty;

  // Priority: reset > err_hit > init > empty-based moves; ERROR only leaves on reset
  always_comb begin
    state_next = S_RESET;
    if (reset) begin
      case (state_reg)
        S_RESET:  state_next = S_INIT;
        S_INIT: begin
          if (err_hit)   state_next = S_ERROR;
          else if (init) state_next = S_INIT;
          else           state_next = S_IDLE;
        end
        S_IDLE, S_ACTIVE: begin
          if (err_hit)        state_next = S_ERROR;
          else if (init)      state_next = S_INIT;
          else if (all_empty) state_next = S_IDLE;
          else                state_next = S_ACTIVE;
        end
        S_ERROR:  state_next = S_ERROR;
        default:  state_next = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= S_RESET;
      state_out  <= ST_RESET;
      idle_out   <= 1'b0;
      active_out <= 1'b0;
      error_out  <= 1'b0;
      error_src  <= '0;
    end else begin
      state_reg  <= state_next;
      state_out  <= state_next;
      idle_out   <= (state_next == S_IDLE);
      active_out <= (state_next == S_ACTIVE);
      error_out  <= (state_next == S_ERROR);
      // Capture only on the entering edge so later errors cannot overwrite the source
      if (state_next == S_RESET) begin
        error_src <= '0;
      end else if (state_next == S_ERROR && state_reg != S_ERROR) begin
        error_src <= err_masked;
      end
    end
  end

  // Thresholds track umbral_in while in INIT and are wiped whenever RESET is entered
  assign cfg_load  = (state_reg == S_INIT);
  assign cfg_clr_n = (state_next != S_RESET);

  fsm_cfg_reg #(
    .W (NUM_FIFOS * TH_W)
  ) u_cfg_reg (
    .clk   (clk),
    .clr_n (cfg_clr_n),
    .load  (cfg_load),
    .d     (umbral_in),
    .q     (umbrales_out)
  );

endmodule
